// File: rtl/rvh_l1d_pkg.sv
// ----------------------------------------------------------------------------
// rvh_l1d_pkg
// Shared encodings for the L1D snoop line-state writer:
//   - MESI line-state encoding (I/S/E/M)
//   - snoop request type encoding
//   - snoop FSM state encoding
//   - L1D bank set-index width
// ----------------------------------------------------------------------------
package rvh_l1d_pkg;

    localparam int L1D_BANK_SET_INDEX_WIDTH = 6;
    localparam int L1D_BANK_WAY_NUM         = 4;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    // Encoding 3 is reserved and behaves like a probe.
    typedef enum logic [1:0] {
        SNP_INV       = 2'd0,
        SNP_SHARE     = 2'd1,
        SNP_NOP_PROBE = 2'd2,
        SNP_RSVD      = 2'd3
    } snp_type_e;

    typedef enum logic [1:0] {
        SNP_ST_IDLE   = 2'd0,
        SNP_ST_LOOKUP = 2'd1,
        SNP_ST_UPDATE = 2'd2,
        SNP_ST_RESP   = 2'd3
    } snp_fsm_e;

endpackage

// File: rtl/rvh_l1d_snp_mesi_next.sv
// ----------------------------------------------------------------------------
// rvh_l1d_snp_mesi_next
// Purely combinational snoop decode: given the snoop type and the current
// MESI state of the target line, produce the post-snoop state and the
// response flags.
// Ports:
//   snp_type_i    : snoop type (INV / SHARE / NOP_PROBE, 3 = NOP_PROBE)
//   cur_state_i   : current MESI state of the line
//   next_state_o  : MESI state after the snoop
//   had_line_o    : line was valid (state != I)
//   dirty_o       : line was modified (state == M)
// ----------------------------------------------------------------------------
module rvh_l1d_snp_mesi_next
    import rvh_l1d_pkg::*;
(
    input  logic [1:0] snp_type_i,
    input  logic [1:0] cur_state_i,
    output logic [1:0] next_state_o,
    output logic       had_line_o,
    output logic       dirty_o
);

    always_comb begin
        next_state_o = cur_state_i;
        case (snp_type_i)
            SNP_INV: begin
                next_state_o = MESI_I;
            end
            SNP_SHARE: begin
                // Only exclusive owners are downgraded; S and I stay put.
                if ((cur_state_i == MESI_E) || (cur_state_i == MESI_M)) begin
                    next_state_o = MESI_S;
                end
            end
            default: begin
                next_state_o = cur_state_i;
            end
        endcase
    end

    assign had_line_o = (cur_state_i != MESI_I);
    assign dirty_o    = (cur_state_i == MESI_M);

endmodule

// File: rtl/rvh_l1d_lst_snp_wr.sv
// ----------------------------------------------------------------------------
// rvh_l1d_lst_snp_wr
// Snoop-side line-state-table (LST) updater for one L1D bank. Accepts one
// snoop at a time, reads the target way's MESI state, writes the post-snoop
// state back through a dedicated LST write port (yielding to the pipeline's
// s0 write), and returns the previous state in a response.
// Ports:
//   clk, rstn                      : clock, async active-low reset
//   snp_req_*                      : snoop request handshake + set/way/type
//   lst_rd_idx_snp / lst_rd_dat_snp: LST read port (combinational data)
//   lst_mesi_wr_*_s0_req           : pipeline-side LST write (has priority)
//   lst_mesi_wr_*_snp              : snoop-side LST write port
//   snp_resp_*                     : response handshake + prev state/flags
// ----------------------------------------------------------------------------
module rvh_l1d_lst_snp_wr
    import rvh_l1d_pkg::*;
#(
    parameter int SET_IDX_W = L1D_BANK_SET_INDEX_WIDTH,
    parameter int WAY_NUM   = L1D_BANK_WAY_NUM
) (
    input  logic                   clk,
    input  logic                   rstn,

    input  logic                   snp_req_valid,
    output logic                   snp_req_ready,
    input  logic [SET_IDX_W-1:0]   snp_req_set_idx,
    input  logic [1:0]             snp_req_way_idx,
    input  logic [1:0]             snp_req_type,

    output logic [SET_IDX_W-1:0]   lst_rd_idx_snp,
    input  logic [2*WAY_NUM-1:0]   lst_rd_dat_snp,

    input  logic                   lst_mesi_wr_en_s0_req,
    input  logic [SET_IDX_W-1:0]   lst_mesi_wr_set_idx_s0_req,
    input  logic [1:0]             lst_mesi_wr_way_idx_s0_req,

    output logic                   lst_mesi_wr_en_snp,
    output logic [SET_IDX_W-1:0]   lst_mesi_wr_set_idx_snp,
    output logic [1:0]             lst_mesi_wr_way_idx_snp,
    output logic [1:0]             lst_mesi_wr_dat_snp,

    output logic                   snp_resp_valid,
    input  logic                   snp_resp_ready,
    output logic [1:0]             snp_resp_prev_state,
    output logic                   snp_resp_had_line,
    output logic                   snp_resp_dirty
);

    snp_fsm_e               state_q;
    logic [SET_IDX_W-1:0]   set_q;
    logic [1:0]             way_q;
    logic [1:0]             type_q;
    logic [1:0]             prev_q;
    logic [1:0]             next_q;
    logic                   had_line_q;
    logic                   dirty_q;

    // Split the LST read word into per-way states.
    logic [1:0] way_state [WAY_NUM];
    for (genvar gi = 0; gi < WAY_NUM; gi++) begin : g_way_split
        assign way_state[gi] = lst_rd_dat_snp[2*gi +: 2];
    end

    logic [1:0] cur_state;
    logic [1:0] dec_next;
    logic       dec_had_line;
    logic       dec_dirty;

    assign cur_state = way_state[way_q];

    rvh_l1d_snp_mesi_next u_mesi_next (
        .snp_type_i   (type_q),
        .cur_state_i  (cur_state),
        .next_state_o (dec_next),
        .had_line_o   (dec_had_line),
        .dirty_o      (dec_dirty)
    );

    // Pipeline write hitting exactly the line under snoop invalidates any
    // state we have read, so the lookup must be redone.
    logic s0_hit;
    assign s0_hit = lst_mesi_wr_en_s0_req
                  && (lst_mesi_wr_set_idx_s0_req == set_q)
                  && (lst_mesi_wr_way_idx_s0_req == way_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= SNP_ST_IDLE;
            set_q      <= '0;
            way_q      <= '0;
            type_q     <= '0;
            prev_q     <= '0;
            next_q     <= '0;
            had_line_q <= 1'b0;
            dirty_q    <= 1'b0;
        end else begin
            case (state_q)
                SNP_ST_IDLE: begin
                    if (snp_req_valid) begin
                        set_q   <= snp_req_set_idx;
                        way_q   <= snp_req_way_idx;
                        type_q  <= snp_req_type;
                        state_q <= SNP_ST_LOOKUP;
                    end
                end
                SNP_ST_LOOKUP: begin
                    if (!s0_hit) begin
                        prev_q     <= cur_state;
                        next_q     <= dec_next;
                        had_line_q <= dec_had_line;
                        dirty_q    <= dec_dirty;
                        state_q    <= SNP_ST_UPDATE;
                    end
                end
                SNP_ST_UPDATE: begin
                    if (lst_mesi_wr_en_s0_req) begin
                        if (s0_hit) begin
                            state_q <= SNP_ST_LOOKUP;
                        end
                    end else begin
                        state_q <= SNP_ST_RESP;
                    end
                end
                SNP_ST_RESP: begin
                    if (snp_resp_ready) begin
                        state_q <= SNP_ST_IDLE;
                    end
                end
                default: begin
                    state_q <= SNP_ST_IDLE;
                end
            endcase
        end
    end

    // Ready is gated by rstn so it reads 0 while reset is held and 1 as soon
    // as it is released.
    assign snp_req_ready = rstn && (state_q == SNP_ST_IDLE);

    assign lst_rd_idx_snp = set_q;

    // The write enable has to react to the pipeline write in the same cycle,
    // so it is decoded from the registered state rather than registered.
    assign lst_mesi_wr_en_snp      = rstn
                                   && (state_q == SNP_ST_UPDATE)
                                   && !lst_mesi_wr_en_s0_req
                                   && (next_q != prev_q);
    assign lst_mesi_wr_set_idx_snp = set_q;
    assign lst_mesi_wr_way_idx_snp = way_q;
    assign lst_mesi_wr_dat_snp     = next_q;

    assign snp_resp_valid      = (state_q == SNP_ST_RESP);
    assign snp_resp_prev_state = prev_q;
    assign snp_resp_had_line   = had_line_q;
    assign snp_resp_dirty      = dirty_q;

endmodule

// File: tb/tb_rvh_l1d_lst_snp_wr.sv
module tb_rvh_l1d_lst_snp_wr;

    localparam int SW = 6;
    localparam logic [1:0] T_INV = 2'd0, T_SHARE = 2'd1, T_NOP = 2'd2, T_RSV = 2'd3;
    localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          snp_req_valid;
    logic          snp_req_ready;
    logic [SW-1:0] snp_req_set_idx;
    logic [1:0]    snp_req_way_idx;
    logic [1:0]    snp_req_type;
    logic [SW-1:0] lst_rd_idx_snp;
    logic [7:0]    lst_rd_dat_snp;
    logic          s0_en;
    logic [SW-1:0] s0_set;
    logic [1:0]    s0_way;
    logic [1:0]    s0_dat;
    logic          wr_en_snp;
    logic [SW-1:0] wr_set_snp;
    logic [1:0]    wr_way_snp;
    logic [1:0]    wr_dat_snp;
    logic          snp_resp_valid;
    logic          snp_resp_ready;
    logic [1:0]    snp_resp_prev_state;
    logic          snp_resp_had_line;
    logic          snp_resp_dirty;

    always #5 clk = ~clk;

    rvh_l1d_lst_snp_wr #(.SET_IDX_W(SW), .WAY_NUM(4)) dut (
        .clk                        (clk),
        .rstn                       (rstn),
        .snp_req_valid              (snp_req_valid),
        .snp_req_ready              (snp_req_ready),
        .snp_req_set_idx            (snp_req_set_idx),
        .snp_req_way_idx            (snp_req_way_idx),
        .snp_req_type               (snp_req_type),
        .lst_rd_idx_snp             (lst_rd_idx_snp),
        .lst_rd_dat_snp             (lst_rd_dat_snp),
        .lst_mesi_wr_en_s0_req      (s0_en),
        .lst_mesi_wr_set_idx_s0_req (s0_set),
        .lst_mesi_wr_way_idx_s0_req (s0_way),
        .lst_mesi_wr_en_snp         (wr_en_snp),
        .lst_mesi_wr_set_idx_snp    (wr_set_snp),
        .lst_mesi_wr_way_idx_snp    (wr_way_snp),
        .lst_mesi_wr_dat_snp        (wr_dat_snp),
        .snp_resp_valid             (snp_resp_valid),
        .snp_resp_ready             (snp_resp_ready),
        .snp_resp_prev_state        (snp_resp_prev_state),
        .snp_resp_had_line          (snp_resp_had_line),
        .snp_resp_dirty             (snp_resp_dirty)
    );

    // Line-state table model: pipeline write wins over snoop write.
    logic [7:0] lst_mem [64];
    assign lst_rd_dat_snp = lst_mem[lst_rd_idx_snp];
    always @(posedge clk) begin
        if (s0_en)
            lst_mem[s0_set][{s0_way, 1'b0} +: 2] <= s0_dat;
        else if (wr_en_snp)
            lst_mem[wr_set_snp][{wr_way_snp, 1'b0} +: 2] <= wr_dat_snp;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int set; int way; int dat; int cyc; } wr_t;
    typedef struct { int prev; int had; int dirty; int cyc; } rsp_t;
    wr_t  exp_wr[$];
    rsp_t exp_rsp[$];

    int checks = 0;
    int errors = 0;
    int resp_done = 0;
    int resp_target = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    logic       v_prev = 1'b0;
    logic       r_prev = 1'b0;
    logic [1:0] f_prev_state;
    logic       f_had, f_dirty;
    always @(negedge clk) begin
        if (!rstn) begin
            v_prev = 1'b0;
            r_prev = 1'b0;
        end else begin
            if (wr_en_snp) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    $display("write set=%0d way=%0d dat=%0d cycle=%0d", wr_set_snp, wr_way_snp, wr_dat_snp, cyc);
                    chk("wr_set", int'(wr_set_snp), e.set);
                    chk("wr_way", int'(wr_way_snp), e.way);
                    chk("wr_dat", int'(wr_dat_snp), e.dat);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end
            if (snp_resp_valid) begin
                chk("busy_req_ready", int'(snp_req_ready), 0);
                if (!v_prev) begin
                    if (exp_rsp.size() == 0) chk("unexpected_resp", 1, 0);
                    else chk("resp_latency_cycle", cyc, exp_rsp[0].cyc);
                end else if (!r_prev) begin
                    chk("stable_prev", int'(snp_resp_prev_state), int'(f_prev_state));
                    chk("stable_had", int'(snp_resp_had_line), int'(f_had));
                    chk("stable_dirty", int'(snp_resp_dirty), int'(f_dirty));
                end
                if (snp_resp_ready && exp_rsp.size() != 0) begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    $display("resp prev=%0d had=%0d dirty=%0d cycle=%0d", snp_resp_prev_state, snp_resp_had_line, snp_resp_dirty, cyc);
                    chk("resp_prev", int'(snp_resp_prev_state), r.prev);
                    chk("resp_had", int'(snp_resp_had_line), r.had);
                    chk("resp_dirty", int'(snp_resp_dirty), r.dirty);
                    resp_done++;
                end
            end
            v_prev = snp_resp_valid;
            r_prev = snp_resp_ready;
            f_prev_state = snp_resp_prev_state;
            f_had = snp_resp_had_line;
            f_dirty = snp_resp_dirty;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int set, input int way, input logic [1:0] dat);
        s0_en = 1'b1; s0_set = SW'(set); s0_way = 2'(way); s0_dat = dat;
        tick();
        s0_en = 1'b0;
    endtask

    task automatic send(input int set, input int way, input logic [1:0] typ, output int hs);
        snp_req_valid = 1'b1; snp_req_set_idx = SW'(set);
        snp_req_way_idx = 2'(way); snp_req_type = typ;
        hs = cyc;
        #1;
        chk("req_ready_idle", int'(snp_req_ready), 1);
        $display("req set=%0d way=%0d type=%0d cycle=%0d", set, way, typ, hs);
        tick();
        snp_req_valid = 1'b0;
    endtask

    task automatic expect_wr(input int set, input int way, input int dat, input int c);
        wr_t e;
        e.set = set; e.way = way; e.dat = dat; e.cyc = c;
        exp_wr.push_back(e);
    endtask

    task automatic expect_rsp(input int prev, input int had, input int dirty, input int c);
        rsp_t r;
        r.prev = prev; r.had = had; r.dirty = dirty; r.cyc = c;
        exp_rsp.push_back(r);
        resp_target++;
    endtask

    task automatic wait_done();
        int n = 0;
        while (resp_done < resp_target && n < 60) begin
            tick();
            n++;
        end
        if (resp_done < resp_target) chk("resp_timeout", resp_done, resp_target);
    endtask

    initial begin
        int hs;
        rstn = 1'b0;
        snp_req_valid = 1'b0; snp_req_set_idx = '0; snp_req_way_idx = '0; snp_req_type = '0;
        s0_en = 1'b0; s0_set = '0; s0_way = '0; s0_dat = '0;
        snp_resp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", int'(snp_req_ready), 0);
        chk("rst_resp_valid", int'(snp_resp_valid), 0);
        chk("rst_wr_en", int'(wr_en_snp), 0);
        chk("rst_prev", int'(snp_resp_prev_state), 0);
        chk("rst_had", int'(snp_resp_had_line), 0);
        chk("rst_dirty", int'(snp_resp_dirty), 0);
        chk("rst_rd_idx", int'(lst_rd_idx_snp), 0);
        rstn = 1'b1;
        #1;
        chk("rel_req_ready", int'(snp_req_ready), 1);
        tick();

        set_line(5, 2, ST_M);  set_line(7, 1, ST_E);  set_line(9, 0, ST_I);
        set_line(3, 3, ST_M);  set_line(4, 1, ST_S);  set_line(6, 0, ST_S);
        set_line(8, 3, ST_E);  set_line(10, 1, ST_M); set_line(12, 0, ST_M);

        // INV on M
        send(5, 2, T_INV, hs);
        expect_wr(5, 2, ST_I, hs + 2); expect_rsp(3, 1, 1, hs + 3);
        wait_done();
        // SHARE on E
        send(7, 1, T_SHARE, hs);
        expect_wr(7, 1, ST_S, hs + 2); expect_rsp(2, 1, 0, hs + 3);
        wait_done();
        // INV on I: no write
        send(9, 0, T_INV, hs);
        expect_rsp(0, 0, 0, hs + 3);
        wait_done();
        // probe on M: no write
        send(3, 3, T_NOP, hs);
        expect_rsp(3, 1, 1, hs + 3);
        wait_done();
        // reserved type acts as probe
        send(4, 1, T_RSV, hs);
        expect_rsp(1, 1, 0, hs + 3);
        wait_done();
        // SHARE on S: no write
        send(6, 0, T_SHARE, hs);
        expect_rsp(1, 1, 0, hs + 3);
        wait_done();

        // s0 write to the same line during UPDATE: re-read, then write I
        set_line(5, 2, ST_M);
        send(5, 2, T_INV, hs);
        expect_wr(5, 2, ST_I, hs + 4); expect_rsp(1, 1, 0, hs + 5);
        tick();
        s0_en = 1'b1; s0_set = 6'd5; s0_way = 2'd2; s0_dat = ST_S;
        tick();
        s0_en = 1'b0;
        wait_done();

        // s0 write to the same line during LOOKUP: lookup repeats
        send(8, 3, T_SHARE, hs);
        expect_wr(8, 3, ST_S, hs + 3); expect_rsp(3, 1, 1, hs + 4);
        s0_en = 1'b1; s0_set = 6'd8; s0_way = 2'd3; s0_dat = ST_M;
        tick();
        s0_en = 1'b0;
        wait_done();

        // s0 to another set for 3 cycles in UPDATE; response back-pressured 4 cycles
        snp_resp_ready = 1'b0;
        send(10, 1, T_INV, hs);
        expect_wr(10, 1, ST_I, hs + 5); expect_rsp(3, 1, 1, hs + 6);
        tick();
        s0_en = 1'b1; s0_set = 6'd11; s0_way = 2'd1; s0_dat = ST_E;
        tick(); tick(); tick();
        s0_en = 1'b0;
        while (cyc < hs + 10) tick();
        snp_resp_ready = 1'b1;
        wait_done();

        // reset during UPDATE abandons the snoop
        send(12, 0, T_INV, hs);
        tick();
        rstn = 1'b0;
        #1;
        chk("rst_mid_wr_en", int'(wr_en_snp), 0);
        chk("rst_mid_resp_valid", int'(snp_resp_valid), 0);
        chk("rst_mid_req_ready", int'(snp_req_ready), 0);
        tick(); tick();
        chk("rst_mid_line_kept", int'(lst_mem[12][1:0]), int'(ST_M));
        rstn = 1'b1;
        #1;
        chk("rst_mid_rel_ready", int'(snp_req_ready), 1);
        repeat (3) tick();
        chk("rst_mid_no_resp", int'(snp_resp_valid), 0);

        // normal operation resumes after reset
        send(12, 0, T_INV, hs);
        expect_wr(12, 0, ST_I, hs + 2); expect_rsp(3, 1, 1, hs + 3);
        wait_done();

        repeat (4) tick();
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_resps", exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvh_l1d_lst_snp_wr.md
RVH_L1D_LST_SNP_WR -- requirements
Module: rvh_l1d_lst_snp_wr

Interface
REQ-001 SHALL have parameter SET_IDX_W, default 6, meaning the L1D bank set-index width (64 sets).
REQ-002 SHALL have parameter WAY_NUM, default 4, meaning ways per set; way index is 2 bits.
REQ-003 SHALL have port clk  input  1  sole clock; all flops on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port snp_req_valid  input  1  snoop request present.
REQ-006 SHALL have port snp_req_ready  output  1  request accepted when valid&ready.
REQ-007 SHALL have port snp_req_set_idx  input  SET_IDX_W  target set.
REQ-008 SHALL have port snp_req_way_idx  input  2  target way, already resolved by upstream tag compare.
REQ-009 SHALL have port snp_req_type  input  2  0=INV, 1=SHARE, 2=NOP_PROBE; 3 is treated as NOP_PROBE.
REQ-010 SHALL have port lst_rd_idx_snp  output  SET_IDX_W  line-state-table read index.
REQ-011 SHALL have port lst_rd_dat_snp  input  2*WAY_NUM  combinational read data, 2 bits per way, way0 in bits [1:0].
REQ-012 SHALL have port lst_mesi_wr_en_s0_req  input  1  pipeline-side line-state write this cycle; it has priority.
REQ-013 SHALL have ports lst_mesi_wr_set_idx_s0_req  input  SET_IDX_W, and lst_mesi_wr_way_idx_s0_req  input  2, giving the pipeline-side write target.
REQ-014 SHALL have ports lst_mesi_wr_en_snp  output  1; lst_mesi_wr_set_idx_snp  output  SET_IDX_W; lst_mesi_wr_way_idx_snp  output  2; lst_mesi_wr_dat_snp  output  2. Together these form the snoop write port.
REQ-015 SHALL have ports snp_resp_valid  output  1, and snp_resp_ready  input  1, forming the response handshake.
REQ-016 SHALL have ports snp_resp_prev_state  output  2; snp_resp_had_line  output  1; snp_resp_dirty  output  1.

Function
REQ-017 SHALL use MESI encoding I=0, S=1, E=2, M=3.
REQ-018 SHALL implement FSM states IDLE, LOOKUP, UPDATE, RESP.
REQ-019 SHALL assert snp_req_ready only in IDLE; on handshake, SHALL capture set/way/type and go to LOOKUP.
REQ-020 LOOKUP: SHALL drive lst_rd_idx_snp=captured set; SHALL register prev = selected way's 2 bits; SHALL compute next state; SHALL go to UPDATE.
REQ-021 SHALL compute next state as: INV -> I; SHARE with E or M -> S; SHARE with S or I -> unchanged; NOP_PROBE -> unchanged.
REQ-022 UPDATE: if next!=prev and lst_mesi_wr_en_s0_req=0, SHALL pulse lst_mesi_wr_en_snp for exactly 1 cycle with the captured set/way and dat=next, then go to RESP.
REQ-023 UPDATE: if next==prev, SHALL NOT issue a write and SHALL go to RESP.
REQ-024 UPDATE with lst_mesi_wr_en_s0_req=1: SHALL NOT write (pipeline wins). If the s0 target equals the captured set/way, SHALL return to LOOKUP (re-read); otherwise SHALL stay in UPDATE.
REQ-025 LOOKUP with an s0 write to the same set/way in that cycle: SHALL stay in LOOKUP and re-read next cycle.
REQ-026 RESP: SHALL hold snp_resp_valid=1 with prev_state=prev, had_line=(prev!=I), dirty=(prev==M) stable until snp_resp_ready; on handshake SHALL go to IDLE.
REQ-027 Minimum latency, request handshake to snp_resp_valid: SHALL be 3 cycles.
REQ-028 SHALL keep at most one snoop outstanding; no back-to-back acceptance in the cycle the response completes.
REQ-029 SHALL hold lst_mesi_wr_en_snp=0 in every state other than UPDATE.

Reset
REQ-030 On rstn low: FSM=IDLE; snp_req_ready=0 while reset is asserted and 1 in the first cycle after release; snp_resp_valid=0; lst_mesi_wr_en_snp=0; all captured and response registers=0.
REQ-031 Reset asserted mid-transaction SHALL abandon it with no write and no response.

Structure
REQ-032 rvh_l1d_pkg SHALL hold the MESI encoding, the snoop-type encoding and L1D_BANK_SET_INDEX_WIDTH.
REQ-033 Next-state/response decode SHALL live in one combinational sub-module, rvh_l1d_snp_mesi_next; the FSM and registers stay in the top module.

Verification
REQ-034 set=5, way=2, stored M, INV -> one write (5,2,I) in cycle 2 after handshake; resp prev=3, had_line=1, dirty=1.
REQ-035 set=7, way=1, stored E, SHARE -> write (7,1,S); resp prev=2, had_line=1, dirty=0.
REQ-036 stored I, INV -> no write; resp prev=0, had_line=0, dirty=0 at 3-cycle latency.
REQ-037 s0 write to (5,2) with dat=S during UPDATE of an INV on (5,2) -> re-read, then write (5,2,I); resp prev=1.
REQ-038 s0 write to another set held for 3 cycles during UPDATE -> snoop write delayed 3 cycles, exactly one pulse; snp_resp_ready held low 4 cycles -> resp fields stable and snp_req_ready=0 throughout.
REQ-039 rstn asserted in UPDATE -> no lst_mesi_wr_en_snp pulse, no response; snp_req_ready=1 in the first cycle after release.
